// File: rtl/ring_pkg.sv
// Shared definitions for the ring-driven display scanner: slot count,
// checker/FSM state encoding, hex glyph table and ring rotation helper.
package ring_pkg;

  localparam int N_SLOTS = 8;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Active-low {g,f,e,d,c,b,a} glyphs for 0..F (b and d in lower case).
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // One ring step: dir=0 moves the hot bit towards the MSB, dir=1 towards the LSB.
  function automatic logic [N_SLOTS-1:0] rot1(input logic [N_SLOTS-1:0] v, input logic dir);
    return dir ? {v[0], v[N_SLOTS-1:1]} : {v[N_SLOTS-2:0], v[N_SLOTS-1]};
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment glyph.
module seg7_hex_decode
  import ring_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = hex7(hex);

endmodule

// File: rtl/ring_display_scanner.sv
// Uses a one-hot ring counter as the digit strobe of an 8-digit multiplexed
// 7-segment display: checks the ring, double-buffers display data, swaps the
// buffers on ring wrap and counts completed frames.
module ring_display_scanner #(
  parameter int N_SLOTS = 8,
  parameter bit DIR     = 1'b0,
  parameter bit HOLD_OK = 1'b1,
  parameter int FCW     = 16
) (
  input  logic                   clk,
  input  logic                   init,
  input  logic [N_SLOTS-1:0]     ring,
  input  logic                   wr_valid,
  input  logic [4*N_SLOTS-1:0]   wr_data,
  output logic                   wr_ready,
  input  logic                   err_clr,
  output logic [N_SLOTS-1:0]     an,
  output logic [6:0]             seg,
  output logic [FCW-1:0]         frame_cnt,
  output logic                   err
);
  import ring_pkg::*;

  localparam int IW = $clog2(N_SLOTS);
  localparam logic [N_SLOTS-1:0] FIRST      = {{(N_SLOTS-1){1'b0}}, 1'b1};
  // The slot that legally precedes FIRST, i.e. FIRST stepped backwards.
  localparam logic [N_SLOTS-1:0] PREV_FIRST = rot1(FIRST, !DIR);

  logic [N_SLOTS-1:0]   ring_p0, ring_p1;
  logic [4*N_SLOTS-1:0] shadow, active;
  logic                 pending;
  state_t               state, state_nx;
  logic                 legal, step_ok, wrap, swap, bump, set_err, wr_acc;
  logic                 vld_p1;
  logic [IW-1:0]        idx_p1;
  logic [3:0]           nib_p1;
  logic [6:0]           glyph_p1;

  assign legal    = $onehot(ring_p0);
  assign step_ok  = (ring_p0 == rot1(ring_p1, DIR)) || (HOLD_OK && (ring_p0 == ring_p1));
  assign wrap     = (ring_p0 == FIRST) && (ring_p1 == PREV_FIRST);
  assign wr_ready = ~pending;
  assign wr_acc   = wr_valid && !pending;
  assign vld_p1   = (state == ST_RUN);

  // Stage p0/p1: register the ring, then delay it one more cycle for step checks and display.
  always_ff @(posedge clk) begin
    if (init) begin
      ring_p0 <= '0;
      ring_p1 <= '0;
    end else begin
      ring_p0 <= ring;
      ring_p1 <= ring_p0;
    end
  end

  // Checker FSM next state: SYNC waits for slot 0, RUN checks every step, FAULT waits for err_clr.
  always_comb begin
    state_nx = state;
    swap     = 1'b0;
    bump     = 1'b0;
    set_err  = 1'b0;
    case (state)
      ST_SYNC: begin
        if (ring_p0 == FIRST) begin
          state_nx = ST_RUN;
          swap     = pending;
        end
      end
      ST_RUN: begin
        if (!legal || !step_ok) begin
          state_nx = ST_FAULT;
          set_err  = 1'b1;
        end else if (wrap) begin
          bump = 1'b1;
          swap = pending;
        end
      end
      ST_FAULT: begin
        if (err_clr) state_nx = ST_SYNC;
      end
      default: state_nx = ST_SYNC;
    endcase
  end

  // Control state: FSM, sticky error, frame counter and shadow-pending flag.
  always_ff @(posedge clk) begin
    if (init) begin
      state     <= ST_SYNC;
      err       <= 1'b0;
      frame_cnt <= '0;
      pending   <= 1'b0;
    end else begin
      state <= state_nx;
      if (set_err)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
      if (bump) frame_cnt <= frame_cnt + 1'b1;
      // A write can only be accepted while nothing is pending, so it never races a swap.
      if (swap)        pending <= 1'b0;
      else if (wr_acc) pending <= 1'b1;
    end
  end

  // Double buffer: writes land in shadow, active only changes at a frame boundary.
  always_ff @(posedge clk) begin
    if (init) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (wr_acc) shadow <= wr_data;
      if (swap)   active <= shadow;
    end
  end

  // Digit index of the delayed strobe (lowest set bit wins).
  always_comb begin
    idx_p1 = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (ring_p1[i]) idx_p1 = IW'(i);
    end
  end

  assign nib_p1 = active[{idx_p1, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .hex (nib_p1),
    .seg (glyph_p1)
  );

  // Stage p2: registered anode/segment drive, blanked outside RUN.
  always_ff @(posedge clk) begin
    if (init) begin
      an  <= '1;
      seg <= 7'h7F;
    end else if (vld_p1) begin
      an  <= ~ring_p1;
      seg <= glyph_p1;
    end else begin
      an  <= '1;
      seg <= 7'h7F;
    end
  end

endmodule

// File: tb/tb_ring_display_scanner.sv
// Bench for ring_display_scanner: two instances (default, and HOLD_OK=0 with
// a 2-bit frame counter), a frame-level reference model and directed scenarios.
module tb_ring_display_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       init_v, wr_valid_v, err_clr_v;
  logic [1:0][7:0]  ring_v;
  logic [1:0][31:0] wr_data_v;

  logic [7:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  logic        err0, err1, rdy0, rdy1;
  logic [15:0] fc0;
  logic [1:0]  fc1;

  ring_display_scanner #(.N_SLOTS(8), .DIR(1'b0), .HOLD_OK(1'b1), .FCW(16)) dut0 (
    .clk(clk), .init(init_v[0]), .ring(ring_v[0]), .wr_valid(wr_valid_v[0]),
    .wr_data(wr_data_v[0]), .wr_ready(rdy0), .err_clr(err_clr_v[0]),
    .an(an0), .seg(seg0), .frame_cnt(fc0), .err(err0));

  ring_display_scanner #(.N_SLOTS(8), .DIR(1'b0), .HOLD_OK(1'b0), .FCW(2)) dut1 (
    .clk(clk), .init(init_v[1]), .ring(ring_v[1]), .wr_valid(wr_valid_v[1]),
    .wr_data(wr_data_v[1]), .wr_ready(rdy1), .err_clr(err_clr_v[1]),
    .an(an1), .seg(seg1), .frame_cnt(fc1), .err(err1));

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [6:0] LIT_SEG [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
  localparam int FCX [4] = '{1, 2, 3, 0};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 waiting for slot 0, 1 scanning, 2 faulted.
  int          m_mode [2];
  logic [7:0]  m_cur  [2];   // ring seen at the last edge
  logic [7:0]  m_prev [2];   // ring seen one edge before that
  logic [7:0]  m_an   [2];
  logic [6:0]  m_seg  [2];
  logic        m_err  [2];
  logic        m_pend [2];
  logic [31:0] m_sh   [2];
  logic [31:0] m_act  [2];
  int          m_fc   [2];

  function automatic bit one_hot(input logic [7:0] v);
    return $countones(v) == 1;
  endfunction

  function automatic logic [7:0] successor(input logic [7:0] v);
    return (v == 8'h80) ? 8'h01 : 8'(v * 2);
  endfunction

  function automatic int digit_of(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v == 8'(1 << i)) return i;
    return 0;
  endfunction

  function automatic bit step_legal(input int d, input logic [7:0] nw, input logic [7:0] old);
    return (nw == successor(old)) || (d == 0 && nw == old);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (init_v[d]) begin
        m_mode[d] <= 0; m_cur[d] <= 8'h00; m_prev[d] <= 8'h00;
        m_an[d] <= 8'hFF; m_seg[d] <= 7'h7F; m_err[d] <= 1'b0;
        m_pend[d] <= 1'b0; m_sh[d] <= 32'h0; m_act[d] <= 32'h0; m_fc[d] <= 0;
      end else begin
        m_cur[d]  <= ring_v[d];
        m_prev[d] <= m_cur[d];
        if (m_mode[d] == 1) begin
          m_an[d]  <= ~m_prev[d];
          m_seg[d] <= GLYPH[(m_act[d] >> (4 * digit_of(m_prev[d]))) & 32'hF];
        end else begin
          m_an[d]  <= 8'hFF;
          m_seg[d] <= 7'h7F;
        end
        if (wr_valid_v[d] && !m_pend[d]) begin
          m_sh[d]   <= wr_data_v[d];
          m_pend[d] <= 1'b1;
        end
        if (m_mode[d] == 0) begin
          if (err_clr_v[d]) m_err[d] <= 1'b0;
          if (m_cur[d] == 8'h01) begin
            m_mode[d] <= 1;
            if (m_pend[d]) begin m_act[d] <= m_sh[d]; m_pend[d] <= 1'b0; end
          end
        end else if (m_mode[d] == 1) begin
          if (!one_hot(m_cur[d]) || !step_legal(d, m_cur[d], m_prev[d])) begin
            m_mode[d] <= 2;
            m_err[d]  <= 1'b1;
          end else begin
            if (err_clr_v[d]) m_err[d] <= 1'b0;
            if (m_cur[d] == 8'h01 && m_prev[d] == 8'h80) begin
              m_fc[d] <= (m_fc[d] + 1) % ((d == 0) ? 65536 : 4);
              if (m_pend[d]) begin m_act[d] <= m_sh[d]; m_pend[d] <= 1'b0; end
            end
          end
        end else begin
          if (err_clr_v[d]) begin m_mode[d] <= 0; m_err[d] <= 1'b0; end
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("an0",  {24'h0, an0},  {24'h0, m_an[0]});
      chk("seg0", {25'h0, seg0}, {25'h0, m_seg[0]});
      chk("err0", {31'h0, err0}, {31'h0, m_err[0]});
      chk("rdy0", {31'h0, rdy0}, {31'h0, ~m_pend[0]});
      chk("fc0",  {16'h0, fc0},  32'(m_fc[0]));
      chk("an1",  {24'h0, an1},  {24'h0, m_an[1]});
      chk("seg1", {25'h0, seg1}, {25'h0, m_seg[1]});
      chk("err1", {31'h0, err1}, {31'h0, m_err[1]});
      chk("rdy1", {31'h0, rdy1}, {31'h0, ~m_pend[1]});
      chk("fc1",  {30'h0, fc1},  32'(m_fc[1]));
    end
  end

  // ---------------- stimulus ----------------
  int pos [2];

  task automatic step(input int d, input logic [7:0] v);
    ring_v[d] = v;
    @(negedge clk);
  endtask

  task automatic rot(input int d, input int n);
    for (int k = 0; k < n; k++) begin
      pos[d] = (pos[d] + 1) % 8;
      step(d, 8'(1 << pos[d]));
    end
  endtask

  initial begin
    int guard;
    init_v = 2'b11; wr_valid_v = '0; err_clr_v = '0; ring_v = '0; wr_data_v = '0;
    pos[0] = 7; pos[1] = 7;
    @(negedge clk);
    @(negedge clk);

    // 1: reset state
    chk("rst_an0", {24'h0, an0}, 32'hFF);
    chk("rst_seg0", {25'h0, seg0}, 32'h7F);
    chk("rst_err0", {31'h0, err0}, 32'h0);
    chk("rst_rdy0", {31'h0, rdy0}, 32'h1);
    chk("rst_fc0", {16'h0, fc0}, 32'h0);
    chk("rst_an1", {24'h0, an1}, 32'hFF);
    init_v = 2'b00;
    chk_on = 1'b1;

    // 2: load digits 0..7 and scan two frames
    wr_valid_v[0] = 1'b1; wr_data_v[0] = 32'h76543210;
    step(0, 8'h00);
    wr_valid_v[0] = 1'b0;
    chk("t2_rdy_busy", {31'h0, rdy0}, 32'h0);
    for (int k = 0; k < 18; k++) begin
      rot(0, 1);
      if (k >= 2) begin
        chk("t2_an", {24'h0, an0}, {24'h0, ~(8'h01 << ((k - 2) % 8))});
        chk("t2_seg", {25'h0, seg0}, {25'h0, LIT_SEG[(k - 2) % 8]});
      end
      if (k == 9) chk("t2_fc", {16'h0, fc0}, 32'd1);
    end
    chk("t2_rdy_free", {31'h0, rdy0}, 32'h1);

    // 3: second write stalls until the first one is swapped in
    wr_valid_v[0] = 1'b1; wr_data_v[0] = 32'h88888888;
    rot(0, 1);
    wr_data_v[0] = 32'h11111111;
    chk("t3_stall", {31'h0, rdy0}, 32'h0);
    guard = 0;
    while (rdy0 == 1'b0 && guard < 20) begin
      rot(0, 1);
      guard++;
    end
    chk("t3_stall_bound", {31'h0, rdy0}, 32'h1);
    rot(0, 1);
    wr_valid_v[0] = 1'b0;
    chk("t3_a_an", {24'h0, an0}, 32'hFE);
    chk("t3_a_seg", {25'h0, seg0}, 32'h00);
    chk("t3_b_pend", {31'h0, rdy0}, 32'h0);
    rot(0, 8);
    chk("t3_b_an", {24'h0, an0}, 32'hFE);
    chk("t3_b_seg", {25'h0, seg0}, 32'h79);

    // 4: multi-hot ring while scanning
    step(0, 8'h03);
    step(0, 8'h03);
    chk("t4_err", {31'h0, err0}, 32'h1);
    step(0, 8'h03);
    chk("t4_blank", {24'h0, an0}, 32'hFF);
    rot(0, 5);
    chk("t4_hold_err", {31'h0, err0}, 32'h1);
    chk("t4_fc_frozen", {16'h0, fc0}, 32'd4);
    err_clr_v[0] = 1'b1;
    step(0, 8'h00);
    err_clr_v[0] = 1'b0;
    chk("t4_clr", {31'h0, err0}, 32'h0);
    pos[0] = 7;
    rot(0, 3);
    chk("t4_resume_an", {24'h0, an0}, 32'hFE);
    chk("t4_resume_seg", {25'h0, seg0}, 32'h79);

    // 5: bad step 01->04, then legal hold on the HOLD_OK=1 instance
    rot(0, 6);
    step(0, 8'h04);
    step(0, 8'h08);
    chk("t5_badstep", {31'h0, err0}, 32'h1);
    err_clr_v[0] = 1'b1;
    step(0, 8'h00);
    err_clr_v[0] = 1'b0;
    pos[0] = 7;
    rot(0, 2);
    step(0, 8'h02);
    step(0, 8'h02);
    chk("t5_hold_ok", {31'h0, err0}, 32'h0);

    // 5b: hold is a fault on the HOLD_OK=0 instance
    rot(1, 2);
    step(1, 8'h02);
    step(1, 8'h04);
    chk("t5_hold_bad", {31'h0, err1}, 32'h1);
    err_clr_v[1] = 1'b1;
    step(1, 8'h00);
    err_clr_v[1] = 1'b0;

    // 6: 2-bit frame counter wraps, then reset mid-frame
    pos[1] = 7;
    rot(1, 8);
    for (int r = 0; r < 4; r++) begin
      rot(1, 8);
      chk("t6_fc", {30'h0, fc1}, 32'(FCX[r]));
    end
    wr_valid_v[1] = 1'b1; wr_data_v[1] = 32'h12345678;
    rot(1, 3);
    wr_valid_v[1] = 1'b0;
    chk("t6_pend", {31'h0, rdy1}, 32'h0);
    init_v[1] = 1'b1;
    rot(1, 1);
    init_v[1] = 1'b0;
    chk("t6_rst_an", {24'h0, an1}, 32'hFF);
    chk("t6_rst_seg", {25'h0, seg1}, 32'h7F);
    chk("t6_rst_fc", {30'h0, fc1}, 32'h0);
    chk("t6_rst_rdy", {31'h0, rdy1}, 32'h1);
    chk("t6_rst_err", {31'h0, err1}, 32'h0);
    rot(1, 1);
    chk("t6_blank", {24'h0, an1}, 32'hFF);
    rot(1, 8);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
